nand_b_b_b: RTL and testbench
=============================

// Module: nand_b_b_b
//
// PURPOSE
//   Bit-level logic primitive: y = ~(a & b) on 1-bit ("b") operands.
//   Used as a leaf cell in generated datapaths and as a CI smoke target for
//   the logic-op lowering flow.
//   Default build is purely combinational. A parameterised output register is
//   available for timing-closure use; it is off by default.
//
// PARAMETERS
//   WIDTH     1  operand/result width in bits; bitwise NAND per lane (default = bool)
//   REGISTER  0  0: y combinational from a,b; 1: y registered, 1-cycle latency
//   RST_VAL   1  value of every y bit while reset asserted (REGISTER=1 only); 1 = NAND(0,0)
//
// PORTS
//   clock   in   1      single clock; only used when REGISTER=1
//   reset   in   1      asynchronous, active-low reset (asserted when reset==0)
//   a       in   WIDTH  operand A
//   b       in   WIDTH  operand B
//   y       out  WIDTH  ~(a & b), bitwise
//
// BEHAVIOUR
//   Interface: one clock (clock); reset is asynchronous and active-low (reset).
//   REGISTER=0 (default):
//   - y = ~(a & b) continuously; zero-cycle latency.
//   - No state; clock and reset have no effect on y, including mid-operation
//     reset assertion.
//   - Inputs driven at a clock edge must be reflected on y before the next edge.
//   - Truth table per bit: 00->1, 01->1, 10->1, 11->0.
//   - X/Z on an input may propagate; any input with a 0 forces y=1.
//   REGISTER=1:
//   - y_q <= ~(a & b) on posedge clock; 1-cycle latency.
//   - reset==0 forces y_q = {WIDTH{RST_VAL}} immediately, without waiting for
//     a clock edge, and holds it while asserted.
//   - First update occurs on the first posedge after reset deasserts.
//   - Inputs sampled on the same edge as deassertion are ignored.
//   No handshake, no backpressure; every cycle is valid.
//   Width rule: lanes are fully independent; no carries and no reduction.
//   WIDTH < 1 is illegal; flag it with an elaboration-time error.
//
// STRUCTURE
//   Shared package (logic_pkg): LOGIC_OP enum (AND, OR, XOR, NAND, NOR, XNOR)
//   and a DEFAULT_BOOL_WIDTH = 1 constant, shared with the sibling and_/or_/xor_
//   cells.
//   One optional sub-module: out_reg, a WIDTH-bit async-active-low-reset
//   register with reset value RST_VAL. Instantiate it in a generate block only
//   when REGISTER=1.
//   Core: a generate-for over WIDTH lanes, one NAND per lane.
//
// TESTING (default parameters unless noted)
//   1 Hold reset (reset=0), a=0,b=0 -> y=1; release reset, y stays 1.
//   2 At successive posedges drive (a,b) = 10, 01, 11. Check y on the next edge
//     -> 1, 1, 0. Each check sees the value of the just-applied inputs
//     (zero latency).
//   3 Assert reset while a=1,b=1 -> y stays 0 (combinational path unaffected).
//   4 WIDTH=8: a=8'hF0, b=8'h3C -> y=8'hCF; a=8'hFF, b=8'hFF -> y=8'h00.
//   5 REGISTER=1: hold reset, a=b=1 -> y=1.
//     Release, next posedge -> y=0; then a=0 -> y=1 one edge later.
//   6 REGISTER=1: assert reset between edges with y=0 -> y=1 immediately, no
//     clock edge needed.

Source files
------------

// File: rtl/logic_pkg.sv
// logic_pkg: shared definitions for the and_/or_/xor_/nand_ logic-op leaf cells
package logic_pkg;

   // Operation selector shared by the logic-op cell family
   typedef enum logic [2:0] {
      OP_AND,
      OP_OR,
      OP_XOR,
      OP_NAND,
      OP_NOR,
      OP_XNOR
   } logic_op_e;

   // Default operand width of the "b" (bool) cell variants
   localparam int DEFAULT_BOOL_WIDTH = 1;

endpackage

// File: rtl/nand_b_b_b_out_reg.sv
// nand_b_b_b_out_reg: WIDTH-bit output register, async active-low reset to RST_VAL
module nand_b_b_b_out_reg
   import logic_pkg::*;
#(
   parameter int   WIDTH   = DEFAULT_BOOL_WIDTH,
   parameter logic RST_VAL = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Capture d each edge; reset forces every bit to RST_VAL without a clock
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_q <= {WIDTH{RST_VAL}};
      else r_q <= i_d;

   assign o_q = r_q;

endmodule

// File: rtl/nand_b_b_b.sv
// nand_b_b_b: bitwise NAND cell, combinational by default, optional output register
module nand_b_b_b
   import logic_pkg::*;
#(
   parameter int   WIDTH    = DEFAULT_BOOL_WIDTH,
   parameter int   REGISTER = 0,
   parameter logic RST_VAL  = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   logic [WIDTH-1:0] w_nand;

   if (WIDTH < 1) begin : g_bad_width
      $error("nand_b_b_b: WIDTH must be at least 1");
   end

   // Lanes are independent: one NAND per bit, no carries or reductions
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      assign w_nand[i] = ~(a[i] & b[i]);
   end

   if (REGISTER != 0) begin : g_reg
      nand_b_b_b_out_reg #(
         .WIDTH  (WIDTH),
         .RST_VAL(RST_VAL)
      ) u_out_reg (
         .i_clk  (clock),
         .i_rst_n(reset),
         .i_d    (w_nand),
         .o_q    (y)
      );
   end else begin : g_comb
      // Clock and reset are deliberately ignored on the combinational build
      logic w_unused;
      assign w_unused = clock ^ reset;
      assign y = w_nand;
   end

endmodule

// File: tb/tb_nand_b_b_b.sv
// tb_nand_b_b_b: directed bench for the NAND cell in combinational, wide and registered builds
module tb_nand_b_b_b;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a0, b0, y0;
   logic [7:0] a8, b8, y8;
   logic       ar, br, yr;
   logic       m_r = 1'b1;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   nand_b_b_b u_comb (
      .clock(clk), .reset(rst_n), .a(a0), .b(b0), .y(y0)
   );

   nand_b_b_b #(.WIDTH(8)) u_wide (
      .clock(clk), .reset(rst_n), .a(a8), .b(b8), .y(y8)
   );

   nand_b_b_b #(.REGISTER(1)) u_reg (
      .clock(clk), .reset(rst_n), .a(ar), .b(br), .y(yr)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Registered model: output is "the NAND of what was seen at the last edge
   // while out of reset", or 1 whenever reset is or was held since then
   always @(posedge clk) if (rst_n === 1'b1) m_r = !(ar && br);
   always @(rst_n) if (rst_n !== 1'b1) m_r = 1'b1;

   // Continuous comparison away from the active edge
   always @(negedge clk) begin
      chk("model_comb", {7'd0, y0}, {7'd0, ~(a0 & b0)});
      chk("model_wide", y8, ~(a8 & b8));
      chk("model_reg", {7'd0, yr}, {7'd0, m_r});
   end

   logic [1:0] vec_ab [3];
   logic       vec_y  [3];
   logic [7:0] w_a [5], w_b [5], w_y [5];

   initial begin
      vec_ab = '{2'b10, 2'b01, 2'b11};
      vec_y  = '{1'b1, 1'b1, 1'b0};
      w_a = '{8'hF0, 8'hFF, 8'h00, 8'hAA, 8'hA5};
      w_b = '{8'h3C, 8'hFF, 8'hFF, 8'h55, 8'hFF};
      w_y = '{8'hCF, 8'h00, 8'hFF, 8'hFF, 8'h5A};
      rst_n = 1'b0;
      a0 = 1'b0; b0 = 1'b0;
      a8 = 8'h00; b8 = 8'h00;
      ar = 1'b1; br = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_comb_y", {7'd0, y0}, 8'd1);
      chk("reset_reg_y", {7'd0, yr}, 8'd1);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("release_comb_y", {7'd0, y0}, 8'd1);
      chk("release_reg_hold", {7'd0, yr}, 8'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 {a0, b0} = vec_ab[i];
         #3 chk("comb_vec", {7'd0, y0}, {7'd0, vec_y[i]});
      end
      #1 chk("reg_first_update", {7'd0, yr}, 8'd0);
      ar = 1'b0;
      @(posedge clk);
      #1 chk("reg_a0", {7'd0, yr}, 8'd1);
      ar = 1'b1;
      @(posedge clk);
      #1 chk("reg_a1", {7'd0, yr}, 8'd0);
      #2 rst_n = 1'b0;
      #1 chk("reg_async_reset", {7'd0, yr}, 8'd1);
      chk("comb_reset_11", {7'd0, y0}, 8'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1 a8 = w_a[i];
         b8 = w_b[i];
         #3 chk("wide_vec", y8, w_y[i]);
      end
      chk("reg_hold_in_reset", {7'd0, yr}, 8'd1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 chk("reg_after_rerelease", {7'd0, yr}, 8'd0);
      repeat (2) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
